// File: rtl/mem_arbiter.sv
// Arbiter for one single-port RAM shared by the instruction-fetch and data ports.
// The data port has priority; a starvation counter forces a fetch grant after STARVE_LIM data grants.
module mem_arbiter #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  // Counter widths cover the legal ranges RD_LAT 1..7 and STARVE_LIM 1..15.
  localparam int unsigned LW = 3;
  localparam int unsigned SW = 4;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mem_cmd;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ready;
  logic          r_d_ready;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic [SW-1:0] r_starve_cnt;
  logic [LW-1:0] r_lat_cnt;
  logic          r_grant_d;

  logic w_starved;
  logic w_grant_d;
  logic w_grant_if;

  // Fetch is forced only once the data port has used up its consecutive-grant allowance.
  assign w_starved  = if_req && (r_starve_cnt == SW'(STARVE_LIM));
  assign w_grant_d  = d_req && !w_starved;
  assign w_grant_if = if_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mem_cmd    <= CMD_NONE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_starve_cnt <= '0;
      r_lat_cnt    <= '0;
      r_grant_d    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d || w_grant_if) begin
            r_state     <= ST_ACCESS;
            r_grant_d   <= w_grant_d;
            r_mem_addr  <= w_grant_d ? d_addr : if_addr;
            r_mem_wdata <= w_grant_d ? d_wdata : '0;
            if (w_grant_d && d_write) begin
              r_mem_cmd <= CMD_WRITE;
              r_lat_cnt <= '0;
            end else begin
              r_mem_cmd <= CMD_READ;
              r_lat_cnt <= LW'(RD_LAT - 1);
            end
            if (w_grant_d && if_req) begin
              if (r_starve_cnt != SW'(STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
              end
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end else begin
            if (r_mem_cmd == CMD_READ) begin
              if (r_grant_d) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_if_rdata <= mem_rdata;
              end
            end
            r_d_ready  <= r_grant_d;
            r_if_ready <= !r_grant_d;
            r_mem_cmd  <= CMD_NONE;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Requests are deliberately not sampled here; the requester updates them on this edge.
          r_d_ready  <= 1'b0;
          r_if_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_cmd   = r_mem_cmd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  assign stall_if  = if_req & ~r_if_ready;
  assign stall_mem = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a timeline model.
// The bench RAM only returns valid read data in the last cycle of an RD_LAT-long hold.
module tb_mem_arbiter;

  localparam int unsigned AW         = 9;
  localparam int unsigned DW         = 16;
  localparam int unsigned RD_LAT     = 3;
  localparam int unsigned STARVE_LIM = 4;
  localparam int unsigned DEPTH      = 1 << AW;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
  ) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Bench RAM: single writer process handles bulk init, preloads and DUT writes.
  logic [DW-1:0] tb_ram [DEPTH];
  int            hold_cnt = 0;
  logic          bulk_en = 1'b0;
  int unsigned   bulk_seed = 0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  function automatic logic [DW-1:0] init_word(int unsigned seed, int unsigned a);
    return DW'((a * 32'h9E37 + seed * 32'h3C6B + 32'h0101) ^ (a << 7));
  endfunction

  always @(posedge clk) begin
    hold_cnt <= (mem_cmd == C_READ) ? hold_cnt + 1 : 0;
    if (bulk_en) begin
      for (int i = 0; i < int'(DEPTH); i++) tb_ram[i] <= init_word(bulk_seed, i);
    end else if (pl_en) begin
      tb_ram[pl_addr] <= pl_data;
    end
    if (mem_cmd == C_WRITE) tb_ram[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = (mem_cmd == C_READ && hold_cnt == int'(RD_LAT - 1)) ? tb_ram[mem_addr] : 16'hDEAD;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bulk_en = 1'b1; bulk_seed = 1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bulk_en = 1'b0;
      if (i == 1) reset = 1'b0;
      #1;
      checks++;
      if ({mem_cmd, if_ready, d_ready, if_rdata, d_rdata, mem_addr, mem_wdata, stall_if, stall_mem} !== 63'd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got cmd=%b ifr=%b dr=%b ifd=%h dd=%h addr=%h wd=%h sif=%b smem=%b expected all zero",
                 i, mem_cmd, if_ready, d_ready, if_rdata, d_rdata, mem_addr, mem_wdata, stall_if, stall_mem);
      end
    end
  endtask

  task automatic test_single_fetch();
    preload(9'h005, 16'hA1B2);
    if_req = 1'b1; if_addr = 9'h005;
    for (int c = 0; c <= int'(RD_LAT) + 2; c++) begin
      logic [1:0] e_cmd;
      logic       e_rdy;
      logic       e_stall;
      if (c == int'(RD_LAT) + 2) if_req = 1'b0;
      #1;
      e_cmd   = (c >= 1 && c <= int'(RD_LAT)) ? C_READ : C_NONE;
      e_rdy   = (c == int'(RD_LAT) + 1);
      e_stall = (c <= int'(RD_LAT));
      checks++;
      if ({mem_cmd, if_ready, stall_if} !== {e_cmd, e_rdy, e_stall} ||
          (e_cmd == C_READ && mem_addr !== 9'h005)) begin
        errors++;
        $display("FAIL fetch_seq cyc%0d: got cmd=%b addr=%h ifr=%b sif=%b expected cmd=%b addr=005 ifr=%b sif=%b",
                 c, mem_cmd, mem_addr, if_ready, stall_if, e_cmd, e_rdy, e_stall);
      end
      if (e_rdy) begin
        checks++;
        if (if_rdata !== 16'hA1B2) begin
          errors++;
          $display("FAIL fetch_data: got %h expected a1b2", if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority_store();
    preload(9'h020, 16'hBEEF);
    if_req = 1'b1; if_addr = 9'h020;
    d_req = 1'b1; d_write = 1'b1; d_addr = 9'h010; d_wdata = 16'h00FF;
    for (int c = 0; c <= int'(RD_LAT) + 5; c++) begin
      logic [1:0]    e_cmd;
      logic [AW-1:0] e_addr;
      logic          e_ifr, e_dr, e_sif, e_smem;
      if (c == 3) d_req = 1'b0;
      if (c == int'(RD_LAT) + 5) if_req = 1'b0;
      #1;
      e_cmd  = C_NONE; e_addr = '0;
      if (c == 1) begin e_cmd = C_WRITE; e_addr = 9'h010; end
      if (c >= 4 && c <= 3 + int'(RD_LAT)) begin e_cmd = C_READ; e_addr = 9'h020; end
      e_dr   = (c == 2);
      e_ifr  = (c == 4 + int'(RD_LAT));
      e_sif  = (c <= 3 + int'(RD_LAT));
      e_smem = (c <= 1);
      checks++;
      if ({mem_cmd, if_ready, d_ready, stall_if, stall_mem} !== {e_cmd, e_ifr, e_dr, e_sif, e_smem} ||
          (e_cmd != C_NONE && mem_addr !== e_addr) || (e_cmd == C_WRITE && mem_wdata !== 16'h00FF)) begin
        errors++;
        $display("FAIL prio_seq cyc%0d: got cmd=%b addr=%h wd=%h ifr=%b dr=%b sif=%b smem=%b expected cmd=%b addr=%h ifr=%b dr=%b sif=%b smem=%b",
                 c, mem_cmd, mem_addr, mem_wdata, if_ready, d_ready, stall_if, stall_mem,
                 e_cmd, e_addr, e_ifr, e_dr, e_sif, e_smem);
      end
      next_cycle();
    end
    checks++;
    if (tb_ram[16] !== 16'h00FF || if_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL prio_result: got ram16=%h ifd=%h expected ram16=00ff ifd=beef", tb_ram[16], if_rdata);
    end
  endtask

  task automatic test_starvation();
    int       n;
    int       events;
    logic     exp_d [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic     chg_d;
    bulk_en = 1'b1; bulk_seed = 5;
    next_cycle();
    bulk_en = 1'b0;
    if_req = 1'b1; if_addr = 9'h040;
    d_req = 1'b1; d_write = 1'b0; d_addr = 9'h050;
    n = 0; events = 0; chg_d = 1'b0;
    while (events < 7 && n < 200) begin
      if (chg_d) d_addr = d_addr + AW'(1);
      chg_d = 1'b0;
      #1;
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        checks++;
        if (d_ready !== exp_d[events] || if_ready !== !exp_d[events]) begin
          errors++;
          $display("FAIL starve_order ev%0d: got dr=%b ifr=%b expected dr=%b", events, d_ready, if_ready, exp_d[events]);
        end
        if (d_ready === 1'b1) begin
          checks++;
          if (d_rdata !== init_word(5, 32'(d_addr))) begin
            errors++;
            $display("FAIL starve_ldata ev%0d: got %h expected %h", events, d_rdata, init_word(5, 32'(d_addr)));
          end
          chg_d = 1'b1;
        end else begin
          checks++;
          if (if_rdata !== init_word(5, 32'h40)) begin
            errors++;
            $display("FAIL starve_fdata: got %h expected %h", if_rdata, init_word(5, 32'h40));
          end
        end
        events++;
      end
      next_cycle();
      n++;
    end
    checks++;
    if (events != 7) begin
      errors++;
      $display("FAIL starve_timeout: got %0d events expected 7", events);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid_read();
    d_req = 1'b1; d_write = 1'b0; d_addr = 9'h060;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) begin reset = 1'b1; d_req = 1'b0; end
      if (c == 3) reset = 1'b0;
      #1;
      if (c == 1 || c == 2) begin
        checks++;
        if (mem_cmd !== C_READ || mem_addr !== 9'h060) begin
          errors++;
          $display("FAIL rstmid_access cyc%0d: got cmd=%b addr=%h expected cmd=01 addr=060", c, mem_cmd, mem_addr);
        end
      end
      if (c >= 3) begin
        checks++;
        if ({mem_cmd, d_ready, if_ready, d_rdata, if_rdata} !== 36'd0) begin
          errors++;
          $display("FAIL rstmid_abort cyc%0d: got cmd=%b dr=%b ifr=%b dd=%h ifd=%h expected all zero",
                   c, mem_cmd, d_ready, if_ready, d_rdata, if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_load_retention();
    logic [DW-1:0] exp_vals [3] = '{16'h1234, 16'h1234, 16'h5678};
    logic          wr_vals  [3] = '{1'b0, 1'b1, 1'b0};
    int            n;
    preload(9'h003, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      d_req = 1'b1; d_write = wr_vals[k]; d_addr = 9'h003; d_wdata = 16'h5678;
      n = 0;
      while (d_ready !== 1'b1 && n < 20) begin next_cycle(); n++; end
      checks++;
      if (d_ready !== 1'b1 || d_rdata !== exp_vals[k]) begin
        errors++;
        $display("FAIL retain_step%0d: got ready=%b rdata=%h expected ready=1 rdata=%h", k, d_ready, d_rdata, exp_vals[k]);
      end
      next_cycle();
      d_req = 1'b0;
      if (k == 1) begin
        checks++;
        if (tb_ram[3] !== 16'h5678) begin
          errors++;
          $display("FAIL retain_store: got ram3=%h expected 5678", tb_ram[3]);
        end
      end
    end
    next_cycle();
  endtask

  // Timeline model: a grant at cycle g holds the command for L cycles, pulses ready at g+L+1
  // and allows the next grant decision at g+L+2.
  task automatic test_random();
    logic [DW-1:0] m_ram [DEPTH];
    logic [DW-1:0] m_if_rd, m_d_rd, g_rdata, g_wdata;
    logic [AW-1:0] g_addr;
    logic [1:0]    g_cmd, e_cmd;
    logic          g_valid, g_port_d, e_ifr, e_dr, if_done, d_done;
    int            g_start, g_len, next_dec;
    int unsigned   m_starve;
    reset = 1'b1; bulk_en = 1'b1; bulk_seed = 9;
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
    reset = 1'b0; bulk_en = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) m_ram[i] = init_word(9, i);
    m_if_rd = '0; m_d_rd = '0; m_starve = 0; next_dec = 0;
    g_valid = 1'b0; g_start = 0; g_len = 0; g_cmd = C_NONE; g_addr = '0; g_wdata = '0;
    g_rdata = '0; g_port_d = 1'b0; if_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 1500 && errors < 10; c++) begin
      e_cmd = C_NONE; e_ifr = 1'b0; e_dr = 1'b0;
      if (g_valid) begin
        if (c >= g_start && c < g_start + g_len) e_cmd = g_cmd;
        if (c == g_start + g_len) begin
          if (g_port_d) begin
            e_dr = 1'b1;
            if (g_cmd == C_READ) m_d_rd = g_rdata;
          end else begin
            e_ifr = 1'b1;
            m_if_rd = g_rdata;
          end
        end
      end
      checks++;
      if ({mem_cmd, if_ready, d_ready, if_rdata, d_rdata} !== {e_cmd, e_ifr, e_dr, m_if_rd, m_d_rd} ||
          (e_cmd != C_NONE && mem_addr !== g_addr) || (e_cmd == C_WRITE && mem_wdata !== g_wdata)) begin
        errors++;
        $display("FAIL rand_regs cyc%0d: got cmd=%b addr=%h wd=%h ifr=%b dr=%b ifd=%h dd=%h expected cmd=%b addr=%h wd=%h ifr=%b dr=%b ifd=%h dd=%h",
                 c, mem_cmd, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata,
                 e_cmd, g_addr, g_wdata, e_ifr, e_dr, m_if_rd, m_d_rd);
      end
      if (if_done) if_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (!if_req && $urandom_range(99) < 50) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(31));
      end
      if (!d_req && $urandom_range(99) < 60) begin
        d_req = 1'b1; d_write = 1'($urandom_range(1)); d_addr = AW'($urandom_range(31));
        d_wdata = DW'($urandom);
      end
      #1;
      checks++;
      if ({stall_if, stall_mem} !== {if_req && !e_ifr, d_req && !e_dr}) begin
        errors++;
        $display("FAIL rand_stall cyc%0d: got sif=%b smem=%b expected sif=%b smem=%b",
                 c, stall_if, stall_mem, if_req && !e_ifr, d_req && !e_dr);
      end
      if (c >= next_dec && (if_req || d_req)) begin
        g_valid  = 1'b1;
        g_start  = c + 1;
        g_port_d = d_req && !(if_req && m_starve == STARVE_LIM);
        g_cmd    = (g_port_d && d_write) ? C_WRITE : C_READ;
        g_addr   = g_port_d ? d_addr : if_addr;
        g_wdata  = g_port_d ? d_wdata : '0;
        g_len    = (g_cmd == C_WRITE) ? 1 : int'(RD_LAT);
        g_rdata  = m_ram[g_addr];
        if (g_cmd == C_WRITE) m_ram[g_addr] = g_wdata;
        m_starve = (g_port_d && if_req) ? ((m_starve < STARVE_LIM) ? m_starve + 1 : m_starve) : 0;
        next_dec = c + g_len + 2;
      end
      if_done = e_ifr;
      d_done  = e_dr;
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_priority_store();
    test_starvation();
    test_reset_mid_read();
    test_load_retention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
